// File: rtl/paint_pkg.sv
// Shared types and constants for the paint controller.
// Holds raster defaults, stamp records and the 3x3 slot-offset table.
package paint_pkg;

   localparam int WIDTH_DEF  = 160;
   localparam int HEIGHT_DEF = 120;
   localparam int NSLOT      = 9;

   typedef logic [2:0] color_t;

   typedef enum logic {
      IDLE,
      STAMP
   } state_t;

   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      logic       brush;
      color_t     color;
   } stamp_t;

   // Two's-complement offsets, raster order: dy outer, dx inner.
   localparam logic [1:0] DX_TBL [NSLOT] = '{
      2'b11, 2'b00, 2'b01,
      2'b11, 2'b00, 2'b01,
      2'b11, 2'b00, 2'b01
   };

   localparam logic [1:0] DY_TBL [NSLOT] = '{
      2'b11, 2'b11, 2'b11,
      2'b00, 2'b00, 2'b00,
      2'b01, 2'b01, 2'b01
   };

   function automatic logic [8:0] sext_off(input logic [1:0] o);
      return {{7{o[1]}}, o};
   endfunction

endpackage

// File: rtl/stamp_gen.sv
// Slot sequencer: walks the stamp slots, applies offsets and clips.
// Produces the coordinate of the slot that follows the next clock edge.
module stamp_gen
   import paint_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int HEIGHT = HEIGHT_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       step,
   input  logic [7:0] new_x,
   input  logic [7:0] new_y,
   input  logic       new_brush,
   input  logic [7:0] cur_x,
   input  logic [7:0] cur_y,
   input  logic       cur_brush,
   output logic [7:0] nxt_x,
   output logic [7:0] nxt_y,
   output logic       nxt_hit,
   output logic       last
);

   localparam logic [8:0] W9 = 9'(WIDTH);
   localparam logic [8:0] H9 = 9'(HEIGHT);

   logic [3:0] slot;
   logic [3:0] idx;
   logic [7:0] cx;
   logic [7:0] cy;
   logic       cb;
   logic [8:0] dx;
   logic [8:0] dy;
   logic [8:0] sx;
   logic [8:0] sy;

   always_comb begin
      cx  = start ? new_x : cur_x;
      cy  = start ? new_y : cur_y;
      cb  = start ? new_brush : cur_brush;
      idx = start ? 4'd0 : slot + 4'd1;
      dx  = '0;
      dy  = '0;
      if (cb && idx < 4'(NSLOT)) begin
         dx = sext_off(DX_TBL[idx]);
         dy = sext_off(DY_TBL[idx]);
      end
      // Bit 8 set means the slot went negative.
      sx      = {1'b0, cx} + dx;
      sy      = {1'b0, cy} + dy;
      nxt_hit = !sx[8] && (sx < W9) && !sy[8] && (sy < H9);
      nxt_x   = sx[7:0];
      nxt_y   = sy[7:0];
      last    = cur_brush ? (slot == 4'(NSLOT - 1)) : 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot <= '0;
      end else if (start) begin
         slot <= '0;
      end else if (step) begin
         slot <= slot + 4'd1;
      end
   end

endmodule

// File: rtl/paint_ctrl.sv
// Paint controller: config register, one-deep pending buffer and
// stamp FSM driving a valid/ready framebuffer write port.
module paint_ctrl
   import paint_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int HEIGHT = HEIGHT_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pkt_valid,
   input  logic       update_config,
   input  logic       brush,
   input  logic [2:0] new_color,
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic       fb_ready,
   output logic       wr_en,
   output logic [7:0] wr_x,
   output logic [7:0] wr_y,
   output logic [2:0] wr_color,
   output logic       busy,
   output logic       dropped
);

   localparam logic [8:0] W9 = 9'(WIDTH);
   localparam logic [8:0] H9 = 9'(HEIGHT);

   state_t state;
   state_t state_n;
   logic   cfg_brush;
   color_t cfg_color;
   stamp_t cur;
   stamp_t pend;
   stamp_t snap;
   stamp_t src;
   logic   pend_valid;
   logic   pend_n;

   logic       pos;
   logic       in_rng;
   logic       done;
   logic       fin;
   logic       start;
   logic       step;
   logic       store;
   logic       drop;
   logic [7:0] nxt_x;
   logic [7:0] nxt_y;
   logic       nxt_hit;
   logic       last;

   always_comb begin
      snap   = '{x: x, y: y, brush: cfg_brush, color: cfg_color};
      pos    = pkt_valid & ~update_config;
      in_rng = ({1'b0, x} < W9) && ({1'b0, y} < H9);
      // A clipped slot has wr_en low and completes without fb_ready.
      done   = (state == STAMP) && (!wr_en || fb_ready);
      fin    = done && last;
      step   = done && !last;
      drop   = pos && (!in_rng || ((state == STAMP) && pend_valid));
      start  = ((state == IDLE) && pos && in_rng)
             || (fin && (pend_valid || (pos && in_rng)));
      store  = (state == STAMP) && !fin && pos && in_rng
             && !pend_valid;
      src    = pend_valid ? pend : snap;

      state_n = state;
      if (start) begin
         state_n = STAMP;
      end else if (fin) begin
         state_n = IDLE;
      end

      pend_n = pend_valid;
      if (store) begin
         pend_n = 1'b1;
      end else if (start && pend_valid) begin
         pend_n = 1'b0;
      end
   end

   stamp_gen #(
      .WIDTH (WIDTH),
      .HEIGHT(HEIGHT)
   ) u_gen (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .step     (step),
      .new_x    (src.x),
      .new_y    (src.y),
      .new_brush(src.brush),
      .cur_x    (cur.x),
      .cur_y    (cur.y),
      .cur_brush(cur.brush),
      .nxt_x    (nxt_x),
      .nxt_y    (nxt_y),
      .nxt_hit  (nxt_hit),
      .last     (last)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cfg_brush  <= 1'b0;
         cfg_color  <= '0;
         cur        <= '0;
         pend       <= '0;
         pend_valid <= 1'b0;
         wr_en      <= 1'b0;
         wr_x       <= '0;
         wr_y       <= '0;
         wr_color   <= '0;
         busy       <= 1'b0;
         dropped    <= 1'b0;
      end else begin
         state      <= state_n;
         pend_valid <= pend_n;
         busy       <= (state_n == STAMP) | pend_n;
         dropped    <= drop;
         if (pkt_valid && update_config) begin
            cfg_brush <= brush;
            cfg_color <= new_color;
         end
         if (store) begin
            pend <= snap;
         end
         if (start) begin
            cur <= src;
         end
         if (start || step) begin
            wr_en    <= nxt_hit;
            wr_x     <= nxt_x;
            wr_y     <= nxt_y;
            wr_color <= start ? src.color : cur.color;
         end else if (fin) begin
            wr_en <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_paint_ctrl.sv
// Directed bench for paint_ctrl: vector table plus hand-built
// sequences for stalls, pending/drop, back-to-back and reset abort.
module tb_paint_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       pkt_valid = 1'b0;
   logic       update_config = 1'b0;
   logic       brush = 1'b0;
   logic [2:0] new_color = '0;
   logic [7:0] x = '0;
   logic [7:0] y = '0;
   logic       fb_ready = 1'b0;
   logic       wr_en;
   logic [7:0] wr_x;
   logic [7:0] wr_y;
   logic [2:0] wr_color;
   logic       busy;
   logic       dropped;

   always #5 clk = ~clk;

   paint_ctrl #(
      .WIDTH (160),
      .HEIGHT(120)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .pkt_valid    (pkt_valid),
      .update_config(update_config),
      .brush        (brush),
      .new_color    (new_color),
      .x            (x),
      .y            (y),
      .fb_ready     (fb_ready),
      .wr_en        (wr_en),
      .wr_x         (wr_x),
      .wr_y         (wr_y),
      .wr_color     (wr_color),
      .busy         (busy),
      .dropped      (dropped)
   );

   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      logic [2:0] c;
   } wr_t;

   typedef struct {
      int pv, uc, br, col, px, py, fb;
      int en, ex, ey, ec, bsy, drp;
   } vec_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   wr_t  seen[$];
   wr_t  expq[$];
   vec_t tbl[$];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock: drive inputs, log any handshake, step past the edge.
   task automatic cyc(input int pv, input int uc, input int br,
                      input int col, input int px, input int py,
                      input int fb);
      pkt_valid     = 1'(pv);
      update_config = 1'(uc);
      brush         = 1'(br);
      new_color     = 3'(col);
      x             = 8'(px);
      y             = 8'(py);
      fb_ready      = 1'(fb);
      if (wr_en && fb_ready) seen.push_back({wr_x, wr_y, wr_color});
      @(posedge clk);
      #1;
      pkt_valid     = 1'b0;
      update_config = 1'b0;
   endtask

   task automatic idle(input int fb);
      cyc(0, 0, 0, 0, 0, 0, fb);
   endtask

   task automatic push_stamp(input int cx, input int cy,
                             input int br, input int col);
      int r;
      r = br ? 1 : 0;
      for (int dy = -r; dy <= r; dy++) begin
         for (int dx = -r; dx <= r; dx++) begin
            if (cx + dx >= 0 && cx + dx < 160 &&
                cy + dy >= 0 && cy + dy < 120)
               expq.push_back({8'(cx + dx), 8'(cy + dy), 3'(col)});
         end
      end
   endtask

   task automatic cmp_writes(input string name);
      int n;
      check({name, " count"}, seen.size(), expq.size());
      n = (seen.size() < expq.size()) ? seen.size() : expq.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s wr%0d", name, i),
               int'(seen[i]), int'(expq[i]));
      seen.delete();
      expq.delete();
   endtask

   task automatic check_zero(input string name);
      check({name, " wr_en"}, int'(wr_en), 0);
      check({name, " wr_x"}, int'(wr_x), 0);
      check({name, " wr_y"}, int'(wr_y), 0);
      check({name, " wr_color"}, int'(wr_color), 0);
      check({name, " busy"}, int'(busy), 0);
      check({name, " dropped"}, int'(dropped), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int  n;
      int  gaps;
      int  stalls;
      logic fb;

      //        pv uc br col  x    y  fb | en  ex   ey  ec b  d
      tbl.push_back('{1, 1, 0, 5,   0,   0, 1, 0,   0,   0, 0, 0, 0});
      tbl.push_back('{1, 0, 0, 0,  10,  20, 1, 1,  10,  20, 5, 1, 0});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 0,   0,   0, 0, 0, 0});
      tbl.push_back('{1, 0, 0, 0, 160,   5, 1, 0,   0,   0, 0, 0, 1});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 0,   0,   0, 0, 0, 0});
      tbl.push_back('{1, 0, 0, 0,   5, 120, 1, 0,   0,   0, 0, 0, 1});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 0,   0,   0, 0, 0, 0});
      tbl.push_back('{1, 1, 1, 3,   0,   0, 1, 0,   0,   0, 0, 0, 0});
      tbl.push_back('{1, 0, 0, 0,   0,   0, 1, 0,   0,   0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 0,   0,   0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 0,   0,   0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 0,   0,   0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 1,   0,   0, 3, 1, 0});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 1,   1,   0, 3, 1, 0});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 0,   0,   0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 1,   0,   1, 3, 1, 0});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 1,   1,   1, 3, 1, 0});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 0,   0,   0, 0, 0, 0});
      tbl.push_back('{1, 0, 0, 0, 159, 119, 1, 1, 158, 118, 3, 1, 0});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 1, 159, 118, 3, 1, 0});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 0,   0,   0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 1, 158, 119, 3, 1, 0});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 1, 159, 119, 3, 1, 0});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 0,   0,   0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 0,   0,   0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 0,   0,   0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 0,   0,   0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 0,   0,   0, 0, 0, 0});

      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      reset_n = 1'b1;

      foreach (tbl[i]) begin
         cyc(tbl[i].pv, tbl[i].uc, tbl[i].br, tbl[i].col,
             tbl[i].px, tbl[i].py, tbl[i].fb);
         check($sformatf("v%0d wr_en", i), int'(wr_en), tbl[i].en);
         if (tbl[i].en != 0) begin
            check($sformatf("v%0d wr_x", i), int'(wr_x), tbl[i].ex);
            check($sformatf("v%0d wr_y", i), int'(wr_y), tbl[i].ey);
            check($sformatf("v%0d wr_color", i), int'(wr_color),
                  tbl[i].ec);
         end
         check($sformatf("v%0d busy", i), int'(busy), tbl[i].bsy);
         check($sformatf("v%0d dropped", i), int'(dropped), tbl[i].drp);
      end
      seen.delete();

      // Back-pressure on the second slot of a 3x3 stamp.
      push_stamp(50, 50, 1, 3);
      cyc(1, 0, 0, 0, 50, 50, 1);
      n = 0;
      stalls = 0;
      while (busy && n < 40) begin
         fb = 1'b1;
         if (wr_en && wr_x == 8'd50 && wr_y == 8'd49 && stalls < 3) begin
            fb = 1'b0;
            stalls++;
         end
         idle(int'(fb));
         if (!fb) begin
            check("stall wr_en", int'(wr_en), 1);
            check("stall wr_x", int'(wr_x), 50);
            check("stall wr_y", int'(wr_y), 49);
            check("stall wr_color", int'(wr_color), 3);
         end
         n++;
      end
      check("stall stalls", stalls, 3);
      check("stall cycles", n, 12);
      cmp_writes("stall");

      // Pending store, overflow drop, mid-stamp CONF, no idle gap.
      push_stamp(20, 20, 1, 3);
      push_stamp(30, 30, 1, 3);
      cyc(1, 0, 0, 0, 20, 20, 1);
      cyc(1, 0, 0, 0, 30, 30, 1);
      check("pendA dropped", int'(dropped), 0);
      check("pendA busy", int'(busy), 1);
      cyc(1, 0, 0, 0, 40, 40, 1);
      check("pendB dropped", int'(dropped), 1);
      cyc(1, 1, 0, 6, 0, 0, 1);
      check("pendB pulse end", int'(dropped), 0);
      n = 0;
      gaps = 0;
      while (busy && n < 40) begin
         if (!wr_en) gaps++;
         idle(1);
         n++;
      end
      check("pend gaps", gaps, 0);
      check("pend cycles", n, 15);
      cmp_writes("pend");

      // POS landing on the completing edge starts straight away.
      push_stamp(5, 5, 0, 6);
      push_stamp(7, 8, 0, 6);
      cyc(1, 0, 0, 0, 5, 5, 1);
      check("b2b first wr_en", int'(wr_en), 1);
      cyc(1, 0, 0, 0, 7, 8, 1);
      check("b2b wr_en", int'(wr_en), 1);
      check("b2b wr_x", int'(wr_x), 7);
      check("b2b wr_y", int'(wr_y), 8);
      check("b2b busy", int'(busy), 1);
      check("b2b dropped", int'(dropped), 0);
      idle(1);
      check("b2b idle busy", int'(busy), 0);
      cmp_writes("b2b");

      // Reset during the fourth slot of a stamp.
      cyc(1, 1, 1, 3, 0, 0, 1);
      cyc(1, 0, 0, 0, 50, 50, 1);
      repeat (3) idle(1);
      check("abort pre wr_x", int'(wr_x), 49);
      check("abort pre wr_y", int'(wr_y), 50);
      reset_n = 1'b0;
      #1;
      check_zero("abort");
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      n = 0;
      repeat (12) begin
         if (wr_en || busy) n++;
         idle(1);
      end
      check("abort quiet", n, 0);
      cyc(1, 0, 0, 0, 10, 10, 1);
      check("post wr_en", int'(wr_en), 1);
      check("post wr_x", int'(wr_x), 10);
      check("post wr_y", int'(wr_y), 10);
      check("post wr_color", int'(wr_color), 0);
      idle(1);
      check("post busy", int'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
